// File: rtl/col_burst_reader_pkg.sv
// Shared types and width helpers for the column burst reader.
package col_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, OUTPUT} col_rd_state_e;

  localparam int DEF_NUM_ELEM   = 1024;
  localparam int DEF_ELEM_WIDTH = 1;
  localparam int DEF_PACK       = 8;

  function automatic int sel_width(input int num_elem);
    return (num_elem > 1) ? $clog2(num_elem) : 1;
  endfunction

  // One extra bit so a full-column length (== num_elem) is representable.
  function automatic int len_width(input int num_elem);
    return $clog2(num_elem) + 1;
  endfunction

endpackage

// File: rtl/col_burst_reader_if.sv
// Request, mux-select and packed-read stream signals of the column burst reader.
interface col_burst_reader_if #(
  parameter int NUM_ELEM   = 1024,
  parameter int ELEM_WIDTH = 1,
  parameter int PACK       = 8
) ();
  import col_pkg::*;

  localparam int SW = sel_width(NUM_ELEM);
  localparam int LW = len_width(NUM_ELEM);
  localparam int DW = PACK * ELEM_WIDTH;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [SW-1:0]         req_addr_i;
  logic [LW-1:0]         req_len_i;
  logic [SW-1:0]         sel_o;
  logic [ELEM_WIDTH-1:0] mux_data_i;
  logic [DW-1:0]         rd_data_o;
  logic                  rd_valid_o;
  logic                  rd_ready_i;
  logic                  rd_last_o;
  logic                  busy_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_len_i, mux_data_i, rd_ready_i,
    output req_ready_o, sel_o, rd_data_o, rd_valid_o, rd_last_o, busy_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_len_i, mux_data_i, rd_ready_i,
    input  req_ready_o, sel_o, rd_data_o, rd_valid_o, rd_last_o, busy_o
  );

endinterface

// File: rtl/col_burst_reader.sv
// Steps the column mux select one column per cycle and packs the sampled
// elements into PACK-element words on a valid/ready stream.
module col_burst_reader
  import col_pkg::*;
#(
  parameter int NUM_ELEM   = 1024,
  parameter int ELEM_WIDTH = 1,
  parameter int PACK       = 8
) (
  input  logic               clk_i,
  input  logic               arst_ni,
  col_burst_reader_if.slave  bus
);

  localparam int SW = sel_width(NUM_ELEM);
  localparam int LW = len_width(NUM_ELEM);
  localparam int DW = PACK * ELEM_WIDTH;
  localparam int KW = (PACK > 1) ? $clog2(PACK) : 1;

  localparam logic [SW-1:0] SEL_LAST  = SW'(NUM_ELEM - 1);
  localparam logic [KW-1:0] SLOT_LAST = KW'(PACK - 1);
  localparam logic [LW-1:0] LEN_MAX   = LW'(NUM_ELEM);

  col_rd_state_e state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [LW-1:0] remaining_q, remaining_d;
  logic [KW-1:0] slot_q, slot_d;
  logic [DW-1:0] pack_q, pack_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      remaining_q <= '0;
      slot_q      <= '0;
      pack_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      remaining_q <= remaining_d;
      slot_q      <= slot_d;
      pack_q      <= pack_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    remaining_d = remaining_q;
    slot_d      = slot_q;
    pack_d      = pack_q;
    valid_d     = valid_q;
    last_d      = last_q;

    case (state_q)
      IDLE: begin
        // A zero-length request is consumed here without leaving IDLE.
        if (bus.req_valid_i && (bus.req_len_i != '0)) begin
          remaining_d = (bus.req_len_i > LEN_MAX) ? LEN_MAX : bus.req_len_i;
          sel_d       = bus.req_addr_i;
          pack_d      = '0;
          slot_d      = '0;
          state_d     = FETCH;
        end
      end

      FETCH: begin
        for (int k = 0; k < PACK; k++) begin
          if (slot_q == KW'(k)) begin
            pack_d[k*ELEM_WIDTH +: ELEM_WIDTH] = bus.mux_data_i;
          end
        end
        remaining_d = remaining_q - LW'(1);
        slot_d      = slot_q + KW'(1);
        sel_d       = (sel_q == SEL_LAST) ? '0 : sel_q + SW'(1);
        if ((slot_q == SLOT_LAST) || (remaining_q == LW'(1))) begin
          state_d = OUTPUT;
          valid_d = 1'b1;
          last_d  = (remaining_q == LW'(1));
        end
      end

      OUTPUT: begin
        if (bus.rd_ready_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          pack_d  = '0;
          slot_d  = '0;
          state_d = last_q ? IDLE : FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.sel_o       = sel_q;
  assign bus.rd_data_o   = pack_q;
  assign bus.rd_valid_o  = valid_q;
  assign bus.rd_last_o   = last_q;

endmodule
